// File: rtl/ssd_pkg.sv
// Shared 7-segment glyph constants, conversion FSM states and helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ssd_pkg;

   // Glyphs are abcdefg, active-low (0 = segment lit).
   localparam logic [6:0] SEG_0     = 7'h01;
   localparam logic [6:0] SEG_1     = 7'h4F;
   localparam logic [6:0] SEG_2     = 7'h12;
   localparam logic [6:0] SEG_3     = 7'h06;
   localparam logic [6:0] SEG_4     = 7'h4C;
   localparam logic [6:0] SEG_5     = 7'h24;
   localparam logic [6:0] SEG_6     = 7'h20;
   localparam logic [6:0] SEG_7     = 7'h0F;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h04;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h60;
   localparam logic [6:0] SEG_C     = 7'h31;
   localparam logic [6:0] SEG_D     = 7'h42;
   localparam logic [6:0] SEG_E     = 7'h30;
   localparam logic [6:0] SEG_F     = 7'h38;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h7E;

   // COMMIT is never registered: the commit happens in the last HEXLD/SHIFT cycle.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEXLD  = 2'd1,
      SHIFT  = 2'd2,
      COMMIT = 2'd3
   } conv_state_e;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   // Double-dabble digit correction applied before each shift.
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Value capture and display bus of the 7-segment scan driver.
// Latency: n/a (wires only).
// Backpressure: load is only honoured while busy is low.
interface ssd_scan_driver_if #(
   parameter int NUM_DIGITS = 8,
   parameter int VALUE_W    = 16
);
   logic [VALUE_W-1:0]    value;
   logic                  load;
   logic                  mode_dec;
   logic                  blank_lz;
   logic [NUM_DIGITS-1:0] dp_mask;
   logic                  busy;
   logic [7:0]            An;
   logic [7:0]            Cathodes;

   modport master (
      output value, load, mode_dec, blank_lz, dp_mask,
      input  busy, An, Cathodes
   );

   modport slave (
      input  value, load, mode_dec, blank_lz, dp_mask,
      output busy, An, Cathodes
   );
endinterface

// File: rtl/ssd_glyph_decode.sv
// Nibble to active-low abcdefg glyph decoder.
// Latency: combinational.
// Backpressure: none.
module ssd_glyph_decode
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Lookup of the sixteen hex glyphs.
   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed 7-segment driver with hex/decimal capture and leading-zero blanking.
// Latency: hex capture 1 cycle busy, decimal VALUE_W cycles; An/Cathodes lag the digit index by 1 cycle.
// Backpressure: load is ignored while busy; the old image stays lit until the new one commits.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int VALUE_W    = 16,
   parameter int DIV_BITS   = 18
) (
   input  logic               ClkPort,
   input  logic               Reset,
   ssd_scan_driver_if.slave   io
);

   localparam int DW    = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(VALUE_W);
   localparam logic [63:0]      DEC_MAX  = pow10(NUM_DIGITS) - 64'd1;
   localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VALUE_W - 1);

   conv_state_e         state_q, state_d;
   logic [VALUE_W-1:0]  val_q, val_d;
   logic [VALUE_W-1:0]  sh_q, sh_d;
   logic [DW-1:0]       bcd_q, bcd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]       digits_q, digits_d;
   logic                ovf_q, ovf_d;
   logic                blz_q, blz_d;
   logic                blz_pend_q, blz_pend_d;
   logic [DIV_BITS-1:0] presc_q, presc_d;
   logic [2:0]          idx_q, idx_d;
   logic [7:0]          an_q, an_d;
   logic [7:0]          cat_q, cat_d;

   logic [DW-1:0] bcd_adj;
   logic [DW-1:0] bcd_shift;
   logic [63:0]   val_ext;
   logic [3:0]    cur_nib;
   logic [6:0]    glyph;
   logic [6:0]    seg;
   logic          nz_above;
   logic          dp_on;

   // Conversion FSM: capture on load, convert, then swap the whole image in one cycle.
   always_comb begin
      state_d    = state_q;
      val_d      = val_q;
      sh_d       = sh_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      digits_d   = digits_q;
      ovf_d      = ovf_q;
      blz_d      = blz_q;
      blz_pend_d = blz_pend_q;
      val_ext    = 64'(val_q);
      for (int i = 0; i < NUM_DIGITS; i++) bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
      // Digits beyond NUM_DIGITS are dropped; any such value is an overflow anyway.
      bcd_shift  = (bcd_adj << 1) | DW'(sh_q[VALUE_W-1]);
      case (state_q)
         IDLE: begin
            if (io.load) begin
               val_d      = io.value;
               sh_d       = io.value;
               bcd_d      = '0;
               cnt_d      = '0;
               blz_pend_d = io.blank_lz;
               state_d    = io.mode_dec ? SHIFT : HEXLD;
            end
         end
         HEXLD: begin
            digits_d = val_ext[DW-1:0];
            ovf_d    = (val_ext >> DW) != 64'd0;
            blz_d    = blz_pend_q;
            state_d  = IDLE;
         end
         SHIFT: begin
            bcd_d = bcd_shift;
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               digits_d = bcd_shift;
               ovf_d    = val_ext > DEC_MAX;
               blz_d    = blz_pend_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan timing and the glyph shown for the current digit index.
   always_comb begin
      presc_d  = presc_q + 1'b1;
      idx_d    = idx_q;
      if (&presc_q) idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
      cur_nib  = 4'h0;
      nz_above = 1'b0;
      dp_on    = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (3'(i) == idx_q) begin
            cur_nib = digits_q[4*i +: 4];
            dp_on   = io.dp_mask[i];
         end
         if (3'(i) >= idx_q && digits_q[4*i +: 4] != 4'h0) nz_above = 1'b1;
      end
      if (ovf_q)                                  seg = SEG_DASH;
      else if (blz_q && idx_q != 3'd0 && !nz_above) seg = SEG_BLANK;
      else                                        seg = glyph;
      an_d        = 8'hFF;
      an_d[idx_q] = 1'b0;
      cat_d       = {seg, ~dp_on};
   end

   ssd_glyph_decode u_glyph (
      .nibble (cur_nib),
      .seg    (glyph)
   );

   // State registers with synchronous reset; reset also aborts any conversion.
   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         state_q    <= IDLE;
         val_q      <= '0;
         sh_q       <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         digits_q   <= '0;
         ovf_q      <= 1'b0;
         blz_q      <= 1'b0;
         blz_pend_q <= 1'b0;
         presc_q    <= '0;
         idx_q      <= '0;
         an_q       <= 8'hFF;
         cat_q      <= 8'hFF;
      end else begin
         state_q    <= state_d;
         val_q      <= val_d;
         sh_q       <= sh_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         digits_q   <= digits_d;
         ovf_q      <= ovf_d;
         blz_q      <= blz_d;
         blz_pend_q <= blz_pend_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         cat_q      <= cat_d;
      end
   end

   assign io.busy     = (state_q != IDLE);
   assign io.An       = an_q;
   assign io.Cathodes = cat_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver at NUM_DIGITS=4, VALUE_W=16, DIV_BITS=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_ssd_scan_driver;

   localparam int ND = 4;
   localparam int VW = 16;
   localparam int DB = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ssd_scan_driver_if #(.NUM_DIGITS(ND), .VALUE_W(VW)) io ();

   ssd_scan_driver #(.NUM_DIGITS(ND), .VALUE_W(VW), .DIV_BITS(DB)) dut (
      .ClkPort (clk),
      .Reset   (rst),
      .io      (io)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse load for one cycle; returns just after the capturing edge.
   task automatic pulse_load(input logic [15:0] v, input logic dec, input logic blz,
                             input logic [3:0] dp);
      io.value    = v;
      io.mode_dec = dec;
      io.blank_lz = blz;
      io.dp_mask  = dp;
      io.load     = 1'b1;
      tick();
      io.load     = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (io.busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
   endtask

   // Watch one full scan and record the cathodes seen for each digit.
   task automatic scan_capture(output logic [31:0] cat);
      logic [7:0] an_exp;
      cat = 'x;
      for (int k = 0; k < 16; k++) begin
         tick();
         for (int d = 0; d < ND; d++) begin
            an_exp    = 8'hFF;
            an_exp[d] = 1'b0;
            if (io.An === an_exp) cat[8*d +: 8] = io.Cathodes;
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] exp_an;
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++; if (io.An !== 8'hFF) begin n_bad++; $display("FAIL reset_an: got %h want %h", io.An, 8'hFF); end
      n_cmp++; if (io.Cathodes !== 8'hFF) begin n_bad++; $display("FAIL reset_cat: got %h want %h", io.Cathodes, 8'hFF); end
      n_cmp++; if (io.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", io.busy); end
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         exp_an = (k < 4) ? 8'hFE : (k < 8) ? 8'hFD : (k < 12) ? 8'hFB : 8'hF7;
         n_cmp++;
         if (io.An !== exp_an) begin n_bad++; $display("FAIL scan_an[%0d]: got %h want %h", k, io.An, exp_an); end
         if (k == 0) begin
            n_cmp++;
            if (io.Cathodes !== 8'h03) begin n_bad++; $display("FAIL first_digit_cat: got %h want %h", io.Cathodes, 8'h03); end
         end
      end
   endtask

   task automatic test_hex();
      int n;
      logic [31:0] cat;
      logic [31:0] exp = {8'h25, 8'h03, 8'h99, 8'h01};
      pulse_load(16'h2048, 1'b0, 1'b0, 4'b0000);
      count_busy(n);
      n_cmp++; if (n != 1) begin n_bad++; $display("FAIL hex_busy_len: got %0d want 1", n); end
      repeat (2) tick();
      scan_capture(cat);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (cat[8*d +: 8] !== exp[8*d +: 8]) begin
            n_bad++; $display("FAIL hex_digit%0d: got %h want %h", d, cat[8*d +: 8], exp[8*d +: 8]);
         end
      end
   endtask

   task automatic test_dash();
      int n;
      logic [31:0] cat;
      pulse_load(16'd12345, 1'b1, 1'b0, 4'b0000);
      count_busy(n);
      n_cmp++; if (n != 16) begin n_bad++; $display("FAIL dash_busy_len: got %0d want 16", n); end
      repeat (2) tick();
      scan_capture(cat);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (cat[8*d +: 8] !== 8'hFD) begin
            n_bad++; $display("FAIL dash_digit%0d: got %h want %h", d, cat[8*d +: 8], 8'hFD);
         end
      end
   endtask

   // Previous image is all dashes, so any early commit shows up during busy.
   task automatic test_dec();
      int n;
      logic [31:0] cat;
      logic [31:0] exp = {8'h25, 8'h03, 8'h99, 8'h01};
      pulse_load(16'd2048, 1'b1, 1'b0, 4'b0000);
      n = 0;
      while (io.busy === 1'b1 && n < 100) begin
         n_cmp++;
         if (io.Cathodes !== 8'hFD) begin
            n_bad++; $display("FAIL dec_hold[%0d]: got %h want %h", n, io.Cathodes, 8'hFD);
         end
         n++;
         tick();
      end
      n_cmp++; if (n != 16) begin n_bad++; $display("FAIL dec_busy_len: got %0d want 16", n); end
      repeat (2) tick();
      scan_capture(cat);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (cat[8*d +: 8] !== exp[8*d +: 8]) begin
            n_bad++; $display("FAIL dec_digit%0d: got %h want %h", d, cat[8*d +: 8], exp[8*d +: 8]);
         end
      end
   endtask

   task automatic test_blank_lz();
      int n;
      logic [31:0] cat;
      logic [31:0] exp = {8'hFF, 8'hFF, 8'hFF, 8'h1E};
      pulse_load(16'd7, 1'b1, 1'b1, 4'b0001);
      count_busy(n);
      n_cmp++; if (n != 16) begin n_bad++; $display("FAIL blz_busy_len: got %0d want 16", n); end
      repeat (2) tick();
      scan_capture(cat);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (cat[8*d +: 8] !== exp[8*d +: 8]) begin
            n_bad++; $display("FAIL blz_digit%0d: got %h want %h", d, cat[8*d +: 8], exp[8*d +: 8]);
         end
      end
   endtask

   // A hex load arriving mid-conversion must not disturb the decimal result.
   task automatic test_back_to_back();
      int n;
      logic [31:0] cat;
      logic [31:0] exp = {8'h25, 8'h03, 8'h99, 8'h01};
      pulse_load(16'd2048, 1'b1, 1'b0, 4'b0000);
      n = 0;
      while (io.busy === 1'b1 && n < 100) begin
         n++;
         if (n == 5) begin
            io.value    = 16'h0013;
            io.mode_dec = 1'b0;
            io.load     = 1'b1;
         end else begin
            io.load = 1'b0;
         end
         tick();
      end
      io.load = 1'b0;
      n_cmp++; if (n != 16) begin n_bad++; $display("FAIL b2b_busy_len: got %0d want 16", n); end
      repeat (2) tick();
      scan_capture(cat);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (cat[8*d +: 8] !== exp[8*d +: 8]) begin
            n_bad++; $display("FAIL b2b_digit%0d: got %h want %h", d, cat[8*d +: 8], exp[8*d +: 8]);
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] cat;
      pulse_load(16'd9999, 1'b1, 1'b0, 4'b0000);
      for (int n = 1; n <= 9; n++) begin
         if (n == 5) begin
            io.value    = 16'h0013;
            io.mode_dec = 1'b0;
            io.load     = 1'b1;
         end else begin
            io.load = 1'b0;
         end
         if (n == 9) rst = 1'b1;
         tick();
      end
      io.load = 1'b0;
      n_cmp++; if (io.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", io.busy); end
      n_cmp++; if (io.An !== 8'hFF) begin n_bad++; $display("FAIL abort_an: got %h want %h", io.An, 8'hFF); end
      n_cmp++; if (io.Cathodes !== 8'hFF) begin n_bad++; $display("FAIL abort_cat: got %h want %h", io.Cathodes, 8'hFF); end
      tick();
      rst = 1'b0;
      tick();
      n_cmp++; if (io.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_after: got %b want 0", io.busy); end
      scan_capture(cat);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (cat[8*d +: 8] !== 8'h03) begin
            n_bad++; $display("FAIL abort_digit%0d: got %h want %h", d, cat[8*d +: 8], 8'h03);
         end
      end
   endtask

   initial begin
      rst         = 1'b1;
      io.value    = '0;
      io.load     = 1'b0;
      io.mode_dec = 1'b0;
      io.blank_lz = 1'b0;
      io.dp_mask  = '0;
      test_reset();
      test_hex();
      test_dash();
      test_dec();
      test_blank_lz();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of active digits, legal range 1..8.
REQ-002 Parameter VALUE_W, default 16, width of the value input, legal range 4..32.
REQ-003 Parameter DIV_BITS, default 18, scan prescaler width; each digit is lit for 2^DIV_BITS clocks.
REQ-004 ClkPort  input  1  system clock, 100 MHz.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 value  input  VALUE_W  number to display, unsigned.
REQ-007 load  input  1  single-cycle capture strobe for value, mode_dec and blank_lz.
REQ-008 mode_dec  input  1  1 = decimal display, 0 = hex display.
REQ-009 blank_lz  input  1  1 = blank leading zero digits.
REQ-010 dp_mask  input  NUM_DIGITS  1 = light the decimal point of that digit.
REQ-011 busy  output  1  high while a capture is being converted.
REQ-012 An  output  8  anodes, active-low, An[0] = rightmost digit.
REQ-013 Cathodes  output  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.

Function
REQ-014 load SHALL be accepted only when busy=0; a load while busy=1 SHALL be ignored with no side effect.
REQ-015 Hex capture: busy SHALL be high for exactly 1 cycle; nibble k of value SHALL become digit k.
REQ-016 Decimal capture: busy SHALL be high for exactly VALUE_W cycles of shift-add-3 (double-dabble) conversion, one value bit per cycle, MSB first.
REQ-017 The displayed digit registers SHALL update atomically in the cycle busy falls; the previous image SHALL stay displayed while busy=1.
REQ-018 Overflow is value > 10^NUM_DIGITS-1 (decimal) or value >= 16^NUM_DIGITS (hex); on overflow every active digit SHALL show dash (segment g only).
REQ-019 Prescaler SHALL count 0..2^DIV_BITS-1 and wrap; on wrap, the digit index SHALL increment and wrap from NUM_DIGITS-1 to 0.
REQ-020 An SHALL drive the bit at the current index low and all other bits high; An[7:NUM_DIGITS] SHALL be constantly 1.
REQ-021 An and Cathodes SHALL be registered, changing one cycle after the index changes.
REQ-022 Hex glyphs SHALL be 0-9 and A,b,C,d,E,F in standard 7-segment form; Dp cathode SHALL be 0 when the dp_mask bit of the current digit is 1.
REQ-023 With blank_lz=1, digits above the most significant non-zero digit SHALL drive segments a-g as 1; digit 0 SHALL never be blanked; Dp still follows dp_mask.
REQ-024 Changing dp_mask SHALL take effect at the next digit-index change without needing a load.

Reset
REQ-025 Reset SHALL clear the prescaler, the digit index, busy, the overflow flag and all digit registers to 0, and drive An=8'hFF and Cathodes=8'hFF.
REQ-026 Reset during a conversion SHALL abort it; the result SHALL be discarded.
REQ-027 The first lit digit after reset release SHALL be digit 0, shown with glyph 0.

Structure
REQ-028 The shared package ssd_pkg SHALL hold the 16 glyph constants plus SEG_BLANK (7'h7F) and SEG_DASH (7'h7E), as abcdefg active-low.
REQ-029 The combinational nibble-to-glyph decoder SHALL be the sub-module ssd_glyph_decode.
REQ-030 The conversion FSM SHALL have states IDLE, HEXLD, SHIFT and COMMIT; COMMIT lasts 0 cycles and is folded into the last SHIFT/HEXLD cycle.

Verification (NUM_DIGITS=4, VALUE_W=16, DIV_BITS=2)
REQ-031 Reset held 3 cycles -> An=8'hFF, Cathodes=8'hFF, busy=0; after release, An cycles FE,FD,FB,F7 with each value held 4 cycles.
REQ-032 Hex load of 16'h2048 with dp_mask=0 -> busy high 1 cycle; digits show 8,4,0,2 with Cathodes 8'h01, 8'h99, 8'h03, 8'h25.
REQ-033 Decimal load of 2048 -> busy high 16 cycles, with digits unchanged until busy falls; then digits 8,4,0,2 as in REQ-032.
REQ-034 Decimal load of 12345 -> all 4 digits show Cathodes 8'hFD (dash).
REQ-035 Decimal load of 7, blank_lz=1, dp_mask=4'b0001 -> digits 3..1 show 8'hFF and digit 0 shows 8'h1E.
REQ-036 A second load at busy cycle 5, then Reset at busy cycle 9 -> the second load is ignored; after Reset the display shows all zeros and busy=0.
